// File: rtl/image_buffer_reader.sv
// Streams a run of bytes out of a single-cycle-latency image buffer onto a valid/ready sink.
// Each address is held for two cycles (FETCH, CAPTURE) so the registered read data lines up with it.
module image_buffer_reader (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        start_in,
    input  logic [15:0] start_address_in,
    input  logic [16:0] byte_count_in,
    input  logic        abort_in,
    output logic [15:0] buffer_read_address_out,
    input  logic [7:0]  buffer_read_data_in,
    output logic        buffer_read_active_out,
    output logic [7:0]  data_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    output logic        data_last_out,
    output logic        busy_out,
    output logic        done_out
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, DRAIN} state_t;

    state_t      state, state_next;
    logic [15:0] address;
    logic [16:0] remaining;
    logic        handshake;
    logic        load;
    logic        launch;
    logic        cancel;
    logic        done_next;

    assign handshake = data_valid_out && data_ready_in;
    assign load      = (state == CAPTURE) && (!data_valid_out || data_ready_in);
    assign launch    = (state == IDLE) && start_in && (byte_count_in != 17'd0);
    assign cancel    = abort_in && (state != IDLE);

    assign buffer_read_address_out = address;
    assign busy_out                = (state != IDLE);
    assign buffer_read_active_out  = busy_out;

    always_ff @(posedge clock_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    if (byte_count_in != 17'd0) state_next = FETCH;
                    else                        done_next  = 1'b1;
                end
            end
            FETCH:   state_next = CAPTURE;
            CAPTURE: begin
                if (load) state_next = (remaining > 17'd1) ? FETCH : DRAIN;
            end
            DRAIN: begin
                if (handshake) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over any load or handshake in the same cycle.
        if (cancel) begin
            state_next = IDLE;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            address        <= 16'h0000;
            remaining      <= 17'd0;
            data_out       <= 8'h00;
            data_valid_out <= 1'b0;
            data_last_out  <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            done_out <= done_next;
            if (cancel) begin
                data_valid_out <= 1'b0;
                data_last_out  <= 1'b0;
            end else begin
                if (launch) begin
                    address   <= start_address_in;
                    remaining <= byte_count_in;
                end
                if (load) begin
                    data_out       <= buffer_read_data_in;
                    data_valid_out <= 1'b1;
                    data_last_out  <= (remaining == 17'd1);
                    if (remaining > 17'd1) begin
                        address   <= address + 16'd1;
                        remaining <= remaining - 17'd1;
                    end
                end else if (handshake) begin
                    data_valid_out <= 1'b0;
                    data_last_out  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_buffer_reader.sv
// Bench for image_buffer_reader: cycle-exact directed scenarios plus randomized streams
// scored against the expected byte run mem[start + i] from a registered buffer model.
module tb_image_buffer_reader;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic [15:0] start_address_in;
    logic [16:0] byte_count_in;
    logic        abort_in;
    logic [15:0] buffer_read_address_out;
    logic [7:0]  buffer_read_data_in;
    logic        buffer_read_active_out;
    logic [7:0]  data_out;
    logic        data_valid_out;
    logic        data_ready_in;
    logic        data_last_out;
    logic        busy_out;
    logic        done_out;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_log [$];
    int checks = 0;
    int errors = 0;

    image_buffer_reader dut (
        .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
        .start_address_in(start_address_in), .byte_count_in(byte_count_in),
        .abort_in(abort_in), .buffer_read_address_out(buffer_read_address_out),
        .buffer_read_data_in(buffer_read_data_in), .buffer_read_active_out(buffer_read_active_out),
        .data_out(data_out), .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
        .data_last_out(data_last_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clock_in = ~clock_in;

    // Image buffer: data for an address appears one cycle after it is presented.
    always @(posedge clock_in) buffer_read_data_in <= mem[buffer_read_address_out];

    task automatic next_cycle();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; data_ready_in = 1'b1;
        start_address_in = 16'h0; byte_count_in = 17'd0;
        repeat (3) next_cycle();
        @(negedge clock_in);
        checks++;
        if ({data_out, buffer_read_address_out, data_valid_out, data_last_out, busy_out,
             done_out, buffer_read_active_out} !== 31'd0)
            begin errors++; $display("FAIL reset_outputs: data=%h addr=%h v=%b l=%b busy=%b done=%b act=%b, required all 0",
                data_out, buffer_read_address_out, data_valid_out, data_last_out, busy_out, done_out, buffer_read_active_out); end
        next_cycle();
        reset_in = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        logic [15:0] exp_addr;
        for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
        data_ready_in = 1'b1;
        start_in = 1'b1; start_address_in = 16'h0000; byte_count_in = 17'd4;
        for (int c = 0; c < 13; c++) begin
            @(negedge clock_in);
            checks++;
            if (data_valid_out !== (c == 3 || c == 5 || c == 7 || c == 9))
                begin errors++; $display("FAIL basic_valid c%0d: got %b", c, data_valid_out); end
            if (data_valid_out && c >= 3) begin
                checks++;
                if (data_out !== 8'h10 + 8'((c - 3) / 2))
                    begin errors++; $display("FAIL basic_data c%0d: got %h required %h", c, data_out, 8'h10 + 8'((c - 3) / 2)); end
            end
            checks++;
            if (data_last_out !== (c == 9) || done_out !== (c == 10))
                begin errors++; $display("FAIL basic_last_done c%0d: last=%b done=%b", c, data_last_out, done_out); end
            checks++;
            if (busy_out !== (c >= 1 && c <= 9) || buffer_read_active_out !== busy_out)
                begin errors++; $display("FAIL basic_busy c%0d: busy=%b act=%b", c, busy_out, buffer_read_active_out); end
            if (c >= 1) begin
                exp_addr = (c - 1) / 2 > 3 ? 16'd3 : 16'((c - 1) / 2);
                checks++;
                if (buffer_read_address_out !== exp_addr)
                    begin errors++; $display("FAIL basic_addr c%0d: got %h required %h", c, buffer_read_address_out, exp_addr); end
            end
            next_cycle();
            start_in = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got [$];
        int dones = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
        start_in = 1'b1; start_address_in = 16'h0000; byte_count_in = 17'd4;
        for (int c = 0; c < 25; c++) begin
            data_ready_in = !(c >= 5 && c <= 9);
            @(negedge clock_in);
            if (c >= 5 && c <= 10) begin
                checks++;
                if (!data_valid_out || data_out !== 8'h11 || buffer_read_address_out !== 16'h0002)
                    begin errors++; $display("FAIL bp_hold c%0d: v=%b data=%h addr=%h required 1/11/0002",
                        c, data_valid_out, data_out, buffer_read_address_out); end
            end
            if (data_valid_out && data_ready_in) got.push_back(data_out);
            if (done_out) dones++;
            next_cycle();
            start_in = 1'b0;
        end
        checks++;
        if (got.size() != 4 || dones != 1)
            begin errors++; $display("FAIL bp_count: bytes=%0d dones=%0d required 4/1", got.size(), dones); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== 8'h10 + 8'(i))
                begin errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got[i], 8'h10 + 8'(i)); end
        end
        data_ready_in = 1'b1;
    endtask

    // Generic scored stream: bytes in order, last on the final byte, held data under stall, one done.
    task automatic run_stream(input logic [15:0] a, input logic [16:0] n, input bit rand_ready);
        int idx = 0, dones = 0, cyc = 0;
        int limit = 10 * int'(n) + 100;
        bit stalled = 1'b0;
        logic [7:0] held_data;
        logic held_last;
        logic [7:0] exp;
        addr_log.delete();
        start_in = 1'b1; start_address_in = a; byte_count_in = n;
        data_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (dones == 0 && cyc < limit) begin
            @(negedge clock_in);
            if (stalled) begin
                checks++;
                if (!data_valid_out || data_out !== held_data || data_last_out !== held_last)
                    begin errors++; $display("FAIL stream_hold: v=%b data=%h last=%b required 1/%h/%b",
                        data_valid_out, data_out, data_last_out, held_data, held_last); end
            end
            if (busy_out && (addr_log.size() == 0 || addr_log[$] !== buffer_read_address_out))
                addr_log.push_back(buffer_read_address_out);
            if (data_valid_out && data_ready_in) begin
                exp = mem[a + 16'(idx)];
                checks++;
                if (data_out !== exp || data_last_out !== (idx == int'(n) - 1))
                    begin errors++; $display("FAIL stream_byte%0d: data=%h last=%b required %h/%b",
                        idx, data_out, data_last_out, exp, idx == int'(n) - 1); end
                idx++;
            end
            stalled = data_valid_out && !data_ready_in;
            held_data = data_out;
            held_last = data_last_out;
            if (done_out) begin
                dones++;
                checks++;
                if (busy_out !== 1'b0)
                    begin errors++; $display("FAIL stream_idle_at_done: busy=%b required 0", busy_out); end
            end
            next_cycle();
            start_in = 1'b0;
            data_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        checks++;
        if (dones != 1 || idx != int'(n))
            begin errors++; $display("FAIL stream_end: dones=%0d bytes=%0d required 1/%0d (timeout if 0 dones)", dones, idx, n); end
        data_ready_in = 1'b1;
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [4];
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        run_stream(16'hFFFE, 17'd4, 1'b1);
        checks++;
        if (addr_log.size() != 4)
            begin errors++; $display("FAIL wrap_addr_count: got %0d required 4", addr_log.size()); end
        for (int i = 0; i < addr_log.size() && i < 4; i++) begin
            checks++;
            if (addr_log[i] !== exp_addr[i])
                begin errors++; $display("FAIL wrap_addr%0d: got %h required %h", i, addr_log[i], exp_addr[i]); end
        end
    endtask

    task automatic test_zero_count();
        start_in = 1'b1; start_address_in = 16'h1234; byte_count_in = 17'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock_in);
            checks++;
            if (done_out !== (c == 1) || busy_out !== 1'b0 || data_valid_out !== 1'b0)
                begin errors++; $display("FAIL zero_count c%0d: done=%b busy=%b v=%b", c, done_out, busy_out, data_valid_out); end
            next_cycle();
            start_in = 1'b0;
        end
    endtask

    task automatic test_start_while_busy();
        int got = 0, dones = 0;
        for (int i = 0; i < 4; i++) mem[16'h0040 + 16'(i)] = 8'hA0 + 8'(i);
        data_ready_in = 1'b1;
        start_in = 1'b1; start_address_in = 16'h0040; byte_count_in = 17'd4;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_in);
            if (data_valid_out && data_ready_in) begin
                checks++;
                if (data_out !== 8'hA0 + 8'(got))
                    begin errors++; $display("FAIL busy_start_byte%0d: got %h required %h", got, data_out, 8'hA0 + 8'(got)); end
                got++;
            end
            if (done_out) dones++;
            next_cycle();
            start_in = (c == 3);
            start_address_in = (c == 3) ? 16'h0300 : 16'h0040;
            byte_count_in    = (c == 3) ? 17'd7 : 17'd4;
        end
        checks++;
        if (got != 4 || dones != 1)
            begin errors++; $display("FAIL busy_start_count: bytes=%0d dones=%0d required 4/1", got, dones); end
    endtask

    task automatic test_abort();
        int dones = 0;
        data_ready_in = 1'b1;
        start_in = 1'b1; start_address_in = 16'h0020; byte_count_in = 17'd8;
        for (int c = 0; c < 11; c++) begin
            @(negedge clock_in);
            if (c == 7) begin
                checks++;
                if ({busy_out, data_valid_out, data_last_out, buffer_read_active_out} !== 4'b0)
                    begin errors++; $display("FAIL abort_idle: busy=%b v=%b l=%b act=%b required 0",
                        busy_out, data_valid_out, data_last_out, buffer_read_active_out); end
            end
            if (c >= 6 && done_out) dones++;
            next_cycle();
            start_in = 1'b0;
            abort_in = (c == 5);
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d pulses required 0", dones); end
        run_stream(16'(32'($urandom)), 17'd5, 1'b1);
    endtask

    task automatic test_reset_mid();
        data_ready_in = 1'b1;
        start_in = 1'b1; start_address_in = 16'h0777; byte_count_in = 17'd8;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock_in);
            if (c == 7) begin
                checks++;
                if ({data_out, buffer_read_address_out, data_valid_out, data_last_out, busy_out,
                     done_out, buffer_read_active_out} !== 31'd0)
                    begin errors++; $display("FAIL reset_mid: data=%h addr=%h v=%b l=%b busy=%b done=%b, required all 0",
                        data_out, buffer_read_address_out, data_valid_out, data_last_out, busy_out, done_out); end
            end
            next_cycle();
            start_in = 1'b0;
            reset_in = (c == 5);
            abort_in = (c == 5);
        end
        abort_in = 1'b0;
        reset_in = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++)
            run_stream(16'(32'($urandom)), 17'($urandom_range(1, 24)), 1'b1);
        run_stream(16'h5000, 17'd1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
